// File: rtl/fetch_pc_gen.sv
// ============================================================================
//  Module   : fetch_pc_gen
//  Purpose  : Y86-64 fetch-stage PC generator with branch prediction, M/W
//             redirects and a RUN / RET_WAIT / HALT control machine.
//             Optional macro FETCH_PERF_EN adds saturating perf counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_pc_gen #(
    parameter int                ADDR_W     = 64,
    parameter int                VALC_BYTES = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic              need_regids,
    input  logic              need_valC,
    input  logic [ADDR_W-1:0] valC,
    input  logic              f_stall,
    input  logic              m_mispredict,
    input  logic [ADDR_W-1:0] m_valA,
    input  logic              w_ret,
    input  logic [ADDR_W-1:0] w_valM,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] valP,
    output logic [ADDR_W-1:0] pred_pc,
    output logic              fetch_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
`endif
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_RET_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_t;

    localparam logic [3:0] c_icode_halt = 4'h0;
    localparam logic [3:0] c_icode_jxx  = 4'h7;
    localparam logic [3:0] c_icode_call = 4'h8;
    localparam logic [3:0] c_icode_ret  = 4'h9;

    localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_valc_inc = ADDR_W'(VALC_BYTES);

    logic [ADDR_W-1:0] r_pc;
    state_t            r_state;
    logic [ADDR_W-1:0] w_regid_inc;
    logic [ADDR_W-1:0] w_const_inc;
    logic              w_pred_taken;

    // Instruction length: opcode byte, optional register byte, optional constant.
    assign w_regid_inc  = need_regids ? c_one : '0;
    assign w_const_inc  = need_valC ? c_valc_inc : '0;
    assign valP         = r_pc + c_one + w_regid_inc + w_const_inc;

    assign w_pred_taken = (icode == c_icode_jxx) || (icode == c_icode_call);
    assign pred_pc      = w_pred_taken ? valC : valP;

    assign pc           = r_pc;
    assign fsm_state    = r_state;
    assign fetch_valid  = (r_state == ST_RUN);

    // Redirects beat stalls; mispredict beats ret; ret may also revive a halted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_state <= ST_RUN;
        end else if (m_mispredict) begin
            r_pc    <= m_valA;
            r_state <= ST_RUN;
        end else if (w_ret) begin
            r_pc    <= w_valM;
            r_state <= ST_RUN;
        end else if (!f_stall && (r_state == ST_RUN)) begin
            case (icode)
                c_icode_ret: begin
                    r_pc    <= valP;
                    r_state <= ST_RET_WAIT;
                end
                c_icode_halt: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_pc <= pred_pc;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (fetch_valid && !f_stall && (r_perf_fetched != 32'hFFFF_FFFF))
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if ((f_stall || (r_state != ST_RUN)) && (r_perf_stall != 32'hFFFF_FFFF))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
// ============================================================================
//  Module   : tb_fetch_pc_gen
//  Purpose  : Directed bench for fetch_pc_gen with a per-cycle reference model
//             and literal checkpoints. Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic        need_regids = 1'b0;
    logic        need_valC = 1'b0;
    logic [63:0] valC = '0;
    logic        f_stall = 1'b0;
    logic        m_mispredict = 1'b0;
    logic [63:0] m_valA = '0;
    logic        w_ret = 1'b0;
    logic [63:0] w_valM = '0;

    logic [63:0] pc, valP, pred_pc;
    logic        fetch_valid;
    logic [1:0]  fsm_state;

    logic [31:0] pc32, valp32, pred32;
    logic        fv32;
    logic [1:0]  st32;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, pf32, ps32;
`endif

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    fetch_pc_gen #(.ADDR_W(64), .VALC_BYTES(8), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .need_regids(need_regids),
        .need_valC(need_valC), .valC(valC), .f_stall(f_stall),
        .m_mispredict(m_mispredict), .m_valA(m_valA), .w_ret(w_ret),
        .w_valM(w_valM), .pc(pc), .valP(valP), .pred_pc(pred_pc),
        .fetch_valid(fetch_valid),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
        .fsm_state(fsm_state)
    );

    fetch_pc_gen #(.ADDR_W(32), .VALC_BYTES(4), .RESET_PC(32'h0)) dut32 (
        .clk(clk), .rst_n(rst_n), .icode(icode), .need_regids(need_regids),
        .need_valC(need_valC), .valC(valC[31:0]), .f_stall(f_stall),
        .m_mispredict(m_mispredict), .m_valA(m_valA[31:0]), .w_ret(w_ret),
        .w_valM(w_valM[31:0]), .pc(pc32), .valP(valp32), .pred_pc(pred32),
        .fetch_valid(fv32),
`ifdef FETCH_PERF_EN
        .perf_fetched(pf32), .perf_stall(ps32),
`endif
        .fsm_state(st32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural PC plus a mode (0 running, 1 awaiting ret, 2 halted).
    localparam int M_RUN = 0, M_RET = 1, M_HALT = 2;
    logic [63:0] m_pc;
    int          m_mode;

    function automatic logic [63:0] exp_valp();
        logic [63:0] len;
        len = 64'd1;
        if (need_regids) len = len + 64'd1;
        if (need_valC)   len = len + 64'd8;
        return m_pc + len;
    endfunction

    function automatic logic [63:0] exp_pred();
        if (icode == 4'd7 || icode == 4'd8) return valC;
        return exp_valp();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc   <= 64'h0;
            m_mode <= M_RUN;
        end else if (m_mispredict) begin
            m_pc   <= m_valA;
            m_mode <= M_RUN;
        end else if (w_ret) begin
            m_pc   <= w_valM;
            m_mode <= M_RUN;
        end else if (!f_stall && m_mode == M_RUN) begin
            if (icode == 4'd9) begin
                m_pc   <= exp_valp();
                m_mode <= M_RET;
            end else if (icode == 4'd0) begin
                m_mode <= M_HALT;
            end else begin
                m_pc   <= exp_pred();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model pc", pc, m_pc);
            chk("model valP", valP, exp_valp());
            chk("model pred_pc", pred_pc, exp_pred());
            chk("model fetch_valid", {63'd0, fetch_valid}, {63'd0, m_mode == M_RUN});
            chk("model fsm_state", {62'd0, fsm_state}, 64'(m_mode));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic jump(input logic [63:0] addr);
        m_mispredict = 1'b1;
        m_valA = addr;
        tick();
        m_mispredict = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset pc", pc, 64'h0);
        chk("reset state", {62'd0, fsm_state}, 64'd0);
        chk("reset fetch_valid", {63'd0, fetch_valid}, 64'd1);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Register-byte instruction from reset
        icode = 4'h6; need_regids = 1'b1; need_valC = 1'b0;
        #1 chk("valP regids", valP, 64'h2);
        tick();
        chk("pc after opq", pc, 64'h2);

        // Both flags set; 32-bit/4-byte instance in parallel
        jump(64'h10);
        icode = 4'h3; need_regids = 1'b1; need_valC = 1'b1;
        #1 chk("valP irmovq", valP, 64'h1A);
        chk("valP32 irmovq", {32'd0, valp32}, 64'h16);
        tick();
        chk("pc irmovq", pc, 64'h1A);

        // Predicted-taken jump then mispredict
        jump(64'h20);
        icode = 4'h7; need_regids = 1'b0; need_valC = 1'b1; valC = 64'h100;
        #1 chk("pred jxx", pred_pc, 64'h100);
        tick();
        chk("pc jxx taken", pc, 64'h100);
        icode = 4'h1; need_valC = 1'b0;
        jump(64'h29);
        chk("pc mispredict", pc, 64'h29);
        chk("state mispredict", {62'd0, fsm_state}, 64'd0);

        // ret: wait for W
        jump(64'h40);
        icode = 4'h9;
        tick();
        icode = 4'h1;
        chk("state ret_wait", {62'd0, fsm_state}, 64'd1);
        chk("fetch_valid ret_wait", {63'd0, fetch_valid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pc ret_wait hold", pc, 64'h41);
        end
        w_ret = 1'b1; w_valM = 64'h80;
        tick();
        w_ret = 1'b0;
        chk("pc ret", pc, 64'h80);
        chk("state ret", {62'd0, fsm_state}, 64'd0);

        // halt, then mispredict beats ret
        icode = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pc halt hold", pc, 64'h80);
        end
        chk("state halt", {62'd0, fsm_state}, 64'd2);
        m_mispredict = 1'b1; m_valA = 64'h50; w_ret = 1'b1; w_valM = 64'h90;
        tick();
        m_mispredict = 1'b0; w_ret = 1'b0;
        chk("pc mis over ret", pc, 64'h50);
        chk("state mis over ret", {62'd0, fsm_state}, 64'd0);

        // ret arriving while halted resumes at the return address
        tick();
        w_ret = 1'b1; w_valM = 64'h90;
        tick();
        w_ret = 1'b0; icode = 4'h1;
        chk("pc ret from halt", pc, 64'h90);

        // Redirect beats stall
        f_stall = 1'b1; m_mispredict = 1'b1; m_valA = 64'h33;
        tick();
        f_stall = 1'b0; m_mispredict = 1'b0;
        chk("pc redirect over stall", pc, 64'h33);

        // Address wrap then stall
        jump(64'hFFFF_FFFF_FFFF_FFFF);
        icode = 4'h1; need_regids = 1'b0; need_valC = 1'b0;
        #1 chk("valP wrap", valP, 64'h0);
        tick();
        chk("pc wrap", pc, 64'h0);
        tick();
        chk("pc after wrap", pc, 64'h1);
        f_stall = 1'b1;
        tick();
        chk("pc stall 1", pc, 64'h1);
        tick();
        chk("pc stall 2", pc, 64'h1);
        f_stall = 1'b0;

        // Asynchronous reset from HALT
        icode = 4'h0;
        tick();
        chk("state halt pre-reset", {62'd0, fsm_state}, 64'd2);
        icode = 4'h1;
        rst_n = 1'b0;
        #1;
        chk("async reset pc", pc, 64'h0);
        chk("async reset state", {62'd0, fsm_state}, 64'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("pc after reset", pc, 64'h1);
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
